color_palette_gen: RTL and testbench

Parametrised platform/ball colour generator for the game datapath. On request, it draws NUM_PLATS platform colours from a free-running 32-bit Galois LFSR, one slot at a time. Duplicates can optionally be excluded. It then picks one platform at random and copies that platform's colour to the ball, so the ball always matches at least one platform. Results are registered and held until the next request. The game FSM consumes them when it spawns a new row.

---
 rtl/color_palette_if.sv | 41 ++++
 rtl/color_palette_gen.sv | 162 ++++++++++++++++
 tb/tb_color_palette_gen.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/color_palette_if.sv
`default_nettype none
// ============================================================================
// Module   : color_palette_if
// Purpose  : Request/result bundle between the game FSM (master) and the
//            platform/ball colour generator (slave).
// Signals  : seed_load, seed  - reseed the generator's LFSR (seed 0 = default)
//            distinct         - ask for pairwise-distinct platform colours
//            req              - start a generation (ignored while busy)
//            busy, valid      - generation in progress / result held
//            plat_colors      - slot i at [i*COLOR_W +: COLOR_W]
//            ball_idx         - platform whose colour the ball copies
//            ball_color       - colour of platform ball_idx
// Revision : 1.0 - initial release
// ============================================================================
interface color_palette_if #(
  parameter int NUM_PLATS = 4,
  parameter int COLOR_W   = 3
);
  localparam int IW = (NUM_PLATS > 1) ? $clog2(NUM_PLATS) : 1;

  logic                           seed_load;
  logic [31:0]                    seed;
  logic                           distinct;
  logic                           req;
  logic                           busy;
  logic                           valid;
  logic [NUM_PLATS*COLOR_W-1:0]   plat_colors;
  logic [IW-1:0]                  ball_idx;
  logic [COLOR_W-1:0]             ball_color;

  modport master (
    output seed_load, seed, distinct, req,
    input  busy, valid, plat_colors, ball_idx, ball_color
  );

  modport slave (
    input  seed_load, seed, distinct, req,
    output busy, valid, plat_colors, ball_idx, ball_color
  );
endinterface
`default_nettype wire

// File: rtl/color_palette_gen.sv
`default_nettype none
// ============================================================================
// Module   : color_palette_gen
// Purpose  : Draws NUM_PLATS platform colours from a free-running 32-bit
//            Galois LFSR, optionally forcing them pairwise distinct, then
//            picks one platform at random and copies its colour to the ball.
//            Results are registered and held until the next accepted req.
// Ports    : clk, reset (synchronous, active-high)
//            bus (color_palette_if.slave) - seed/req inputs, busy/valid and
//            colour results, all outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
module color_palette_gen #(
  parameter int          NUM_PLATS = 4,
  parameter int          COLOR_W   = 3,
  parameter logic [31:0] SEED      = 32'h7FFF_FFFF
) (
  input  logic           clk,
  input  logic           reset,
  color_palette_if.slave bus
);
  localparam int          IW   = (NUM_PLATS > 1) ? $clog2(NUM_PLATS) : 1;
  localparam int          PW   = NUM_PLATS * COLOR_W;
  localparam logic [31:0] TAPS = 32'h8020_0003;
  // With more platforms than colours, distinct mode could never finish.
  localparam bit          DIST_OK = (NUM_PLATS <= (1 << COLOR_W));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAW  = 2'd1,
    S_CHECK = 2'd2,
    S_PICK  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [IW-1:0]      slot_q, slot_d;
  logic               dist_q, dist_d;
  logic [COLOR_W-1:0] cand_q, cand_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic [PW-1:0]      plat_q, plat_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [COLOR_W-1:0] ball_q, ball_d;

  logic               hit;
  logic [IW-1:0]      pick_idx;
  logic [COLOR_W-1:0] pick_color;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    dist_d  = dist_q;
    cand_d  = cand_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    plat_d  = plat_q;
    idx_d   = idx_q;
    ball_d  = ball_q;

    // LFSR runs every cycle; a reseed replaces this cycle's step.
    if (bus.seed_load) begin
      lfsr_d = (bus.seed == 32'h0) ? SEED : bus.seed;
    end else begin
      lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
    end

    // Collision against slots already committed in this generation.
    hit = 1'b0;
    for (int j = 0; j < NUM_PLATS; j++) begin
      if ((IW'(j) < slot_q) && (plat_q[j*COLOR_W +: COLOR_W] == cand_q)) begin
        hit = dist_q;
      end
    end

    pick_idx   = IW'(lfsr_q[15:0] % 16'(NUM_PLATS));
    pick_color = '0;
    for (int i = 0; i < NUM_PLATS; i++) begin
      if (IW'(i) == pick_idx) begin
        pick_color = plat_q[i*COLOR_W +: COLOR_W];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          slot_d  = '0;
          dist_d  = bus.distinct & DIST_OK;
          valid_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        cand_d  = lfsr_q[COLOR_W-1:0];
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (hit) begin
          // Linear probe to the next colour; terminates within NUM_PLATS-1 steps.
          cand_d = cand_q + COLOR_W'(1);
        end else begin
          for (int i = 0; i < NUM_PLATS; i++) begin
            if (IW'(i) == slot_q) begin
              plat_d[i*COLOR_W +: COLOR_W] = cand_q;
            end
          end
          if (slot_q == IW'(NUM_PLATS - 1)) begin
            state_d = S_PICK;
          end else begin
            slot_d  = slot_q + IW'(1);
            state_d = S_DRAW;
          end
        end
      end
      S_PICK: begin
        idx_d   = pick_idx;
        ball_d  = pick_color;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      slot_q  <= '0;
      dist_q  <= 1'b0;
      cand_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      plat_q  <= '0;
      idx_q   <= '0;
      ball_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      slot_q  <= slot_d;
      dist_q  <= dist_d;
      cand_q  <= cand_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      plat_q  <= plat_d;
      idx_q   <= idx_d;
      ball_q  <= ball_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.valid       = valid_q;
  assign bus.plat_colors = plat_q;
  assign bus.ball_idx    = idx_q;
  assign bus.ball_color  = ball_q;
endmodule
`default_nettype wire

// File: tb/tb_color_palette_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_color_palette_gen
// Purpose  : Self-checking bench for color_palette_gen. Three instances
//            (4x3-bit, 2x1-bit, 3x1-bit) are compared with a reference model
//            that derives each result from the LFSR stream and the
//            generation rules with plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_color_palette_gen;
  localparam logic [31:0] SEED = 32'h7FFF_FFFF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [31:0] r0_pc;
  int          r0_bi, r0_bc;

  always #5 clk = ~clk;

  color_palette_if #(.NUM_PLATS(4), .COLOR_W(3)) b4 ();
  color_palette_if #(.NUM_PLATS(2), .COLOR_W(1)) b2 ();
  color_palette_if #(.NUM_PLATS(3), .COLOR_W(1)) b3 ();

  color_palette_gen #(.NUM_PLATS(4), .COLOR_W(3), .SEED(SEED)) u4 (.clk(clk), .reset(reset), .bus(b4.slave));
  color_palette_gen #(.NUM_PLATS(2), .COLOR_W(1), .SEED(SEED)) u2 (.clk(clk), .reset(reset), .bus(b2.slave));
  color_palette_gen #(.NUM_PLATS(3), .COLOR_W(1), .SEED(SEED)) u3 (.clk(clk), .reset(reset), .bus(b3.slave));

  function automatic logic [31:0] lstep(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
  endfunction

  // Bench copy of each generator's LFSR value, tracked from reset/reseed events.
  logic [31:0] m4, m2, m3;
  always @(posedge clk) begin
    m4 <= reset ? SEED : (b4.seed_load ? ((b4.seed == 32'h0) ? SEED : b4.seed) : lstep(m4));
    m2 <= reset ? SEED : lstep(m2);
    m3 <= reset ? SEED : lstep(m3);
  end

  // Expected result of a request accepted in a cycle whose LFSR value is l0.
  // Cycle t after acceptance sees the LFSR stepped t times.
  function automatic void model(input logic [31:0] l0, input int n, input int cw, input bit d,
                                output logic [31:0] pc, output int bi, output int bc, output int lat);
    int          m, t, c;
    int          col [8];
    logic [31:0] l;
    bit          dd, taken;
    m  = 1 << cw;
    dd = d && (n <= m);
    l  = lstep(l0);
    t  = 1;
    pc = '0;
    for (int s = 0; s < n; s++) begin
      c = int'(l) & (m - 1);
      l = lstep(l);
      t++;
      forever begin
        taken = 1'b0;
        for (int k = 0; k < s; k++) if (col[k] == c) taken = 1'b1;
        if (!(dd && taken)) break;
        c = (c + 1) % m;
        l = lstep(l);
        t++;
      end
      col[s] = c;
      pc = pc | (32'(c) << (s * cw));
      l = lstep(l);
      t++;
    end
    bi  = int'(l[15:0]) % n;
    bc  = col[bi];
    lat = t;
  endfunction

  task automatic req4(input bit d, output logic [31:0] pc, output int bi, output int bc,
                      output int lat, output logic [31:0] l0, output bit acc);
    b4.req = 1'b1; b4.distinct = d; l0 = m4;
    @(posedge clk); #1;
    b4.req = 1'b0; b4.distinct = 1'($urandom);
    acc = (b4.busy === 1'b1) && (b4.valid === 1'b0);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (b4.valid === 1'b1) begin lat = k; break; end
    end
    pc = '0; pc[11:0] = b4.plat_colors; bi = int'(b4.ball_idx); bc = int'(b4.ball_color);
  endtask

  task automatic req2(input bit d, output logic [31:0] pc, output int bi, output int bc,
                      output int lat, output logic [31:0] l0, output bit acc);
    b2.req = 1'b1; b2.distinct = d; l0 = m2;
    @(posedge clk); #1;
    b2.req = 1'b0; b2.distinct = 1'($urandom);
    acc = (b2.busy === 1'b1) && (b2.valid === 1'b0);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (b2.valid === 1'b1) begin lat = k; break; end
    end
    pc = '0; pc[1:0] = b2.plat_colors; bi = int'(b2.ball_idx); bc = int'(b2.ball_color);
  endtask

  task automatic req3(input bit d, output logic [31:0] pc, output int bi, output int bc,
                      output int lat, output logic [31:0] l0, output bit acc);
    b3.req = 1'b1; b3.distinct = d; l0 = m3;
    @(posedge clk); #1;
    b3.req = 1'b0; b3.distinct = 1'($urandom);
    acc = (b3.busy === 1'b1) && (b3.valid === 1'b0);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (b3.valid === 1'b1) begin lat = k; break; end
    end
    pc = '0; pc[2:0] = b3.plat_colors; bi = int'(b3.ball_idx); bc = int'(b3.ball_color);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (b4.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", b4.busy); end
    n_checks++; if (b4.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", b4.valid); end
    n_checks++; if (b4.plat_colors !== 12'h0) begin n_fail++; $display("FAIL reset_plat: got %h want 000", b4.plat_colors); end
    n_checks++; if (b4.ball_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", b4.ball_idx); end
    n_checks++; if (b4.ball_color !== 3'd0) begin n_fail++; $display("FAIL reset_ball: got %0d want 0", b4.ball_color); end
    n_checks++; if ({b2.busy, b2.valid, b3.busy, b3.valid} !== 4'b0) begin
      n_fail++; $display("FAIL reset_small: got %b want 0000", {b2.busy, b2.valid, b3.busy, b3.valid});
    end
  endtask

  task automatic test_basic();
    logic [31:0] pc, l0, epc; int bi, bc, lat, ebi, ebc, elat; bit acc;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    req4(1'b0, pc, bi, bc, lat, l0, acc);
    model(SEED, 4, 3, 1'b0, epc, ebi, ebc, elat);
    n_checks++; if (!acc) begin n_fail++; $display("FAIL basic_accept: busy/valid after E0 got %b%b want 10", b4.busy, b4.valid); end
    n_checks++; if (lat != 9) begin n_fail++; $display("FAIL basic_latency: got %0d want 9", lat); end
    n_checks++; if (pc !== epc) begin n_fail++; $display("FAIL basic_colors: got %h want %h", pc, epc); end
    n_checks++; if (bi != ebi) begin n_fail++; $display("FAIL basic_idx: got %0d want %0d", bi, ebi); end
    n_checks++; if (bc != int'((pc >> (3 * bi)) & 32'h7)) begin n_fail++; $display("FAIL basic_ball_slot: got %0d want %0d", bc, (pc >> (3 * bi)) & 32'h7); end
    n_checks++; if (bc != ebc) begin n_fail++; $display("FAIL basic_ball: got %0d want %0d", bc, ebc); end
    r0_pc = epc; r0_bi = ebi; r0_bc = ebc;
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc, l0, epc; int bi, bc, lat, ebi, ebc, elat; bit acc;
    for (int r = 0; r < 3; r++) begin
      n_checks++; if (b4.valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_before: got %b want 1", b4.valid); end
      req4(1'b0, pc, bi, bc, lat, l0, acc);
      model(l0, 4, 3, 1'b0, epc, ebi, ebc, elat);
      n_checks++; if (!acc) begin n_fail++; $display("FAIL b2b_accept: run %0d not accepted", r); end
      n_checks++; if (lat != 9) begin n_fail++; $display("FAIL b2b_latency: got %0d want 9", lat); end
      n_checks++; if ({pc, bi, bc} !== {epc, ebi, ebc}) begin
        n_fail++; $display("FAIL b2b_result: got %h/%0d/%0d want %h/%0d/%0d", pc, bi, bc, epc, ebi, ebc);
      end
    end
  endtask

  task automatic test_distinct();
    logic [31:0] pc, l0, epc, sd; int bi, bc, lat, ebi, ebc, elat; bit acc, dup;
    for (int r = 0; r < 1000; r++) begin
      sd = $urandom;
      b4.seed_load = 1'b1; b4.seed = sd;
      @(posedge clk); #1;
      b4.seed_load = 1'b0;
      req4(1'b1, pc, bi, bc, lat, l0, acc);
      model((sd == 32'h0) ? SEED : sd, 4, 3, 1'b1, epc, ebi, ebc, elat);
      dup = 1'b0;
      for (int a = 0; a < 4; a++)
        for (int b = a + 1; b < 4; b++)
          if (((pc >> (3 * a)) & 32'h7) == ((pc >> (3 * b)) & 32'h7)) dup = 1'b1;
      n_checks++; if (!acc) begin n_fail++; $display("FAIL dist_accept: run %0d not accepted", r); end
      n_checks++; if (dup) begin n_fail++; $display("FAIL dist_unique: got %h want 4 distinct colours", pc); end
      n_checks++; if (lat < 9 || lat > 21 || lat != elat) begin n_fail++; $display("FAIL dist_latency: got %0d want %0d", lat, elat); end
      n_checks++; if ({pc, bi, bc} !== {epc, ebi, ebc}) begin
        n_fail++; $display("FAIL dist_result: seed %h got %h/%0d/%0d want %h/%0d/%0d", sd, pc, bi, bc, epc, ebi, ebc);
      end
    end
  endtask

  task automatic test_small_configs();
    logic [31:0] pc, l0, epc; int bi, bc, lat, ebi, ebc, elat; bit acc;
    for (int r = 0; r < 20; r++) begin
      req2(1'b1, pc, bi, bc, lat, l0, acc);
      model(l0, 2, 1, 1'b1, epc, ebi, ebc, elat);
      n_checks++; if (!acc) begin n_fail++; $display("FAIL n2_accept: run %0d not accepted", r); end
      n_checks++; if (pc != 32'd1 && pc != 32'd2) begin n_fail++; $display("FAIL n2_colors: got %h want 1 or 2", pc); end
      n_checks++; if ({pc, bi, bc, lat} !== {epc, ebi, ebc, elat}) begin
        n_fail++; $display("FAIL n2_result: got %h/%0d/%0d/%0d want %h/%0d/%0d/%0d", pc, bi, bc, lat, epc, ebi, ebc, elat);
      end
    end
    for (int r = 0; r < 20; r++) begin
      req3(1'b1, pc, bi, bc, lat, l0, acc);
      model(l0, 3, 1, 1'b1, epc, ebi, ebc, elat);
      n_checks++; if (!acc) begin n_fail++; $display("FAIL n3_accept: run %0d not accepted", r); end
      n_checks++; if (lat != 7) begin n_fail++; $display("FAIL n3_latency: got %0d want 7", lat); end
      n_checks++; if ({pc, bi, bc} !== {epc, ebi, ebc}) begin
        n_fail++; $display("FAIL n3_result: got %h/%0d/%0d want %h/%0d/%0d", pc, bi, bc, epc, ebi, ebc);
      end
    end
  endtask

  task automatic test_seed_load();
    logic [31:0] pc, l0, epc, pa; int bi, bc, lat, ebi, ebc, elat, ba, ca; bit acc;
    b4.seed_load = 1'b1; b4.seed = 32'h0;
    @(posedge clk); #1;
    b4.seed_load = 1'b0;
    req4(1'b0, pc, bi, bc, lat, l0, acc);
    n_checks++; if ({pc, bi, bc} !== {r0_pc, r0_bi, r0_bc}) begin
      n_fail++; $display("FAIL seed_zero: got %h/%0d/%0d want %h/%0d/%0d", pc, bi, bc, r0_pc, r0_bi, r0_bc);
    end
    model(32'hDEAD_BEEF, 4, 3, 1'b1, epc, ebi, ebc, elat);
    for (int r = 0; r < 2; r++) begin
      b4.seed_load = 1'b1; b4.seed = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      b4.seed_load = 1'b0;
      req4(1'b1, pc, bi, bc, lat, l0, acc);
      if (r == 0) begin pa = pc; ba = bi; ca = bc; end
      n_checks++; if ({pc, bi, bc, lat} !== {epc, ebi, ebc, elat}) begin
        n_fail++; $display("FAIL seed_beef: run %0d got %h/%0d/%0d/%0d want %h/%0d/%0d/%0d", r, pc, bi, bc, lat, epc, ebi, ebc, elat);
      end
    end
    n_checks++; if ({pc, bi, bc} !== {pa, ba, ca}) begin
      n_fail++; $display("FAIL seed_repeat: got %h/%0d/%0d want %h/%0d/%0d", pc, bi, bc, pa, ba, ca);
    end
  endtask

  task automatic test_ball_spread();
    logic [31:0] pc, l0, epc; int bi, bc, lat, ebi, ebc, elat; bit acc;
    int cnt [3];
    cnt = '{0, 0, 0};
    for (int r = 0; r < 1000; r++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      req3(1'($urandom), pc, bi, bc, lat, l0, acc);
      model(l0, 3, 1, 1'b0, epc, ebi, ebc, elat);
      n_checks++; if (bi < 0 || bi > 2 || bi != ebi || bc != ebc) begin
        n_fail++; $display("FAIL spread_idx: got %0d/%0d want %0d/%0d", bi, bc, ebi, ebc);
      end
      if (bi >= 0 && bi <= 2) cnt[bi]++;
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (cnt[i] < 250) begin n_fail++; $display("FAIL spread_count: index %0d got %0d want >=250", i, cnt[i]); end
    end
  endtask

  task automatic test_req_while_busy();
    logic [31:0] l0, epc, pc; int ebi, ebc, elat, k;
    l0 = m4;
    b4.req = 1'b1; b4.distinct = 1'b0;
    @(posedge clk); #1;
    b4.req = 1'b0;
    repeat (2) @(posedge clk);
    #1 b4.req = 1'b1;
    @(posedge clk); #1;
    b4.req = 1'b0;
    k = 3;
    while (b4.valid !== 1'b1 && k < 40) begin @(posedge clk); #1; k++; end
    model(l0, 4, 3, 1'b0, epc, ebi, ebc, elat);
    n_checks++; if (k != 9) begin n_fail++; $display("FAIL busy_req_latency: got %0d want 9", k); end
    repeat (12) @(posedge clk);
    #1;
    pc = '0; pc[11:0] = b4.plat_colors;
    n_checks++; if ({b4.busy, b4.valid} !== 2'b01) begin n_fail++; $display("FAIL busy_req_single: busy/valid got %b%b want 01", b4.busy, b4.valid); end
    n_checks++; if ({pc, int'(b4.ball_idx), int'(b4.ball_color)} !== {epc, ebi, ebc}) begin
      n_fail++; $display("FAIL busy_req_hold: got %h/%0d/%0d want %h/%0d/%0d", pc, b4.ball_idx, b4.ball_color, epc, ebi, ebc);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] pc, l0; int bi, bc, lat; bit acc;
    b4.req = 1'b1; b4.distinct = 1'b0;
    @(posedge clk); #1;
    b4.req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++; if ({b4.busy, b4.valid} !== 2'b00) begin n_fail++; $display("FAIL midreset_flags: got %b%b want 00", b4.busy, b4.valid); end
    n_checks++; if ({b4.plat_colors, b4.ball_idx, b4.ball_color} !== 17'h0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h/%0d/%0d want 0", b4.plat_colors, b4.ball_idx, b4.ball_color);
    end
    req4(1'b0, pc, bi, bc, lat, l0, acc);
    n_checks++; if ({pc, bi, bc, lat} !== {r0_pc, r0_bi, r0_bc, 9}) begin
      n_fail++; $display("FAIL midreset_rerun: got %h/%0d/%0d/%0d want %h/%0d/%0d/9", pc, bi, bc, lat, r0_pc, r0_bi, r0_bc);
    end
  endtask

  initial begin
    b4.req = 1'b0; b4.distinct = 1'b0; b4.seed_load = 1'b0; b4.seed = 32'h0;
    b2.req = 1'b0; b2.distinct = 1'b0; b2.seed_load = 1'b0; b2.seed = 32'h0;
    b3.req = 1'b0; b3.distinct = 1'b0; b3.seed_load = 1'b0; b3.seed = 32'h0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_distinct();
    test_small_configs();
    test_seed_load();
    test_ball_spread();
    test_req_while_busy();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
